ex_muldiv_unit: RTL and testbench

Execute-stage multiply/divide engine that consumes the ID/EX pipeline register outputs: source operands, `funct`, and an R-type qualifier. It runs MIPS MULT/MULTU/DIV/DIVU iteratively, owns the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO. While an operation is in flight it returns a stall request to the pipeline-register enable logic.

---
 rtl/ex_muldiv_unit_if.sv | 23 ++
 rtl/ex_muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle for the execute-stage multiply/divide unit.
// The master drives the ID/EX operands. The slave returns status and HI/LO.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             op_valid;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, funct, rs_data, rt_data,
    input  busy, stall, mf_data, hi, lo
  );

  modport slave (
    input  op_valid, funct, rs_data, rt_data,
    output busy, stall, mf_data, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU engine that owns HI/LO and serves MFxx/MTxx.
// Divide support is compiled in only when MULDIV_DIVIDE_EN is defined.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  ex_muldiv_unit_if.slave  pipe_io
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
`ifdef MULDIV_DIVIDE_EN
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd3
  } state_t;
`endif

  state_t             state_q;
  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               negRes_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               isMove;
  logic               isMul;
  logic               hiloOp;
  logic               accept;
  logic               signedOp;
  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] accMul_d;
  logic [2*WIDTH-1:0] product;

  assign isMove = (pipe_io.funct == F_MFHI) || (pipe_io.funct == F_MTHI) ||
                  (pipe_io.funct == F_MFLO) || (pipe_io.funct == F_MTLO);
  assign isMul  = (pipe_io.funct == F_MULT) || (pipe_io.funct == F_MULTU);

`ifdef MULDIV_DIVIDE_EN
  logic               isDiv;
  logic               isDiv_q;
  logic               negRem_q;
  logic               divZero_q;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] accDiv_d;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  assign isDiv  = (pipe_io.funct == F_DIV) || (pipe_io.funct == F_DIVU);
  assign hiloOp = pipe_io.op_valid && (isMove || isMul || isDiv);

  // Restoring step: shift the next dividend bit into the remainder, keep the difference if non-negative.
  assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divTrial = divShift - {1'b0, mcand_q};
  assign accDiv_d = divTrial[WIDTH] ? {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign quotFix = divZero_q ? {WIDTH{1'b1}}
                             : (negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
  assign hiloOp = pipe_io.op_valid && (isMove || isMul);
`endif

  assign accept   = hiloOp && !busy_q;
  assign signedOp = !pipe_io.funct[0];
  assign aNeg     = signedOp && pipe_io.rs_data[WIDTH-1];
  assign bNeg     = signedOp && pipe_io.rt_data[WIDTH-1];
  assign aMag     = aNeg ? -pipe_io.rs_data : pipe_io.rs_data;
  assign bMag     = bNeg ? -pipe_io.rt_data : pipe_io.rt_data;

  // Shift-add step: the carry-out is kept as bit 2*WIDTH-1 after the right shift, so full-scale operands cannot overflow.
  assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign accMul_d = {mulSum, acc_q[WIDTH-1:1]};
  assign product  = negRes_q ? -acc_q : acc_q;

  assign pipe_io.busy  = busy_q;
  assign pipe_io.stall = busy_q && hiloOp;
  assign pipe_io.hi    = hi_q;
  assign pipe_io.lo    = lo_q;

  always_comb begin
    pipe_io.mf_data = '0;
    if (pipe_io.op_valid && pipe_io.funct == F_MFHI) begin
      pipe_io.mf_data = hi_q;
    end else if (pipe_io.op_valid && pipe_io.funct == F_MFLO) begin
      pipe_io.mf_data = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      negRes_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIVIDE_EN
      isDiv_q   <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            negRes_q <= aNeg ^ bNeg;
            if (pipe_io.funct == F_MTHI) hi_q <= pipe_io.rs_data;
            if (pipe_io.funct == F_MTLO) lo_q <= pipe_io.rs_data;
            if (isMul) begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
              mcand_q <= aMag;
              acc_q   <= {{WIDTH{1'b0}}, bMag};
`ifdef MULDIV_DIVIDE_EN
              isDiv_q <= 1'b0;
            end else if (isDiv) begin
              state_q   <= S_DIV;
              busy_q    <= 1'b1;
              mcand_q   <= bMag;
              acc_q     <= {{WIDTH{1'b0}}, aMag};
              isDiv_q   <= 1'b1;
              negRem_q  <= aNeg;
              divZero_q <= (pipe_io.rt_data == '0);
`endif
            end
          end
        end
        S_MUL: begin
          acc_q <= accMul_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
`ifdef MULDIV_DIVIDE_EN
        S_DIV: begin
          acc_q <= accDiv_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
`endif
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
          if (isDiv_q) begin
            lo_q <= quotFix;
            hi_q <= remFix;
          end else begin
            {hi_q, lo_q} <= product;
          end
`else
          {hi_q, lo_q} <= product;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed test-plan steps plus randomized
// operations checked against a plain-arithmetic HI/LO reference model.
module tb_ex_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic clk;
  logic rst;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  int          expBusy;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .pipe_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      $error("[TB] assertion %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = v;
    bus.funct    = f;
    bus.rs_data  = a;
    bus.rt_data  = b;
  endtask

  // Architectural effect of one accepted instruction, from the ISA definition.
  task automatic modelStep(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0]        p;
    expBusy = 0;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    case (f)
      F_MTHI: mHi = a;
      F_MTLO: mLo = a;
      F_MULT: begin
        p = sa * sb;
        {mHi, mLo} = p;
        expBusy = 33;
      end
      F_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {mHi, mLo} = p;
        expBusy = 33;
      end
`ifdef MULDIV_DIVIDE_EN
      F_DIV: begin
        expBusy = 33;
        if (b == 0) begin
          mLo = 32'hFFFF_FFFF;
          mHi = a;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          mLo = sq[31:0];
          mHi = sr[31:0];
        end
      end
      F_DIVU: begin
        expBusy = 33;
        if (b == 0) begin
          mLo = 32'hFFFF_FFFF;
          mHi = a;
        end else begin
          mLo = a / b;
          mHi = a % b;
        end
      end
`endif
      default: ;
    endcase
  endtask

  // Present one instruction from idle, release it after acceptance, then measure the busy window.
  task automatic runOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expMf;
    int          cycles;
    expMf = (f == F_MFHI) ? mHi : (f == F_MFLO) ? mLo : 32'd0;
    applyStimulus(1'b1, f, a, b);
    #1;
    checkOutput("stall_at_issue", 64'(bus.stall), 64'd0);
    checkOutput("mf_data_at_issue", 64'(bus.mf_data), 64'(expMf));
    modelStep(f, a, b);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", 64'(cycles), 64'(expBusy));
    checkOutput("hi", 64'(bus.hi), 64'(mHi));
    checkOutput("lo", 64'(bus.lo), 64'(mLo));
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] functTable [9];
    int         cycles;
    functTable = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, F_ADD};

    rst = 1'b1;
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_stall", 64'(bus.stall), 64'd0);
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);
    checkOutput("reset_mf_data", 64'(bus.mf_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    runOp(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu_full_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    checkOutput("multu_full_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
    runOp(F_MULT, 32'hFFFF_FFFE, 32'd3);
    runOp(F_DIV, 32'hFFFF_FFF9, 32'd2);
    runOp(F_DIVU, 32'd7, 32'd0);
    runOp(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp(F_DIV, 32'hFFFF_FFF9, 32'd0);
    runOp(F_MFHI, 32'd0, 32'd0);
    runOp(F_MFLO, 32'd0, 32'd0);

    // Dependent MFLO right behind a MULT, with an ADD slipped into the stalled window.
    applyStimulus(1'b1, F_MULT, 32'd3, 32'd4);
    modelStep(F_MULT, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, F_MFLO, 32'd0, 32'd0);
    #1;
    cycles = 0;
    while (bus.stall === 1'b1 && cycles < 100) begin
      if (cycles == 10) begin
        applyStimulus(1'b1, F_ADD, 32'd1, 32'd2);
        #1;
        checkOutput("add_not_stalled", 64'(bus.stall), 64'd0);
        checkOutput("add_busy", 64'(bus.busy), 64'd1);
        applyStimulus(1'b1, F_MFLO, 32'd0, 32'd0);
        #1;
      end
      cycles++;
      @(negedge clk);
      #1;
    end
    checkOutput("mflo_stall_cycles", 64'(cycles), 64'd33);
    checkOutput("mflo_released", 64'(bus.mf_data), 64'd12);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);

    runOp(F_MTHI, 32'h0000_1234, 32'd0);
    runOp(F_MFHI, 32'd0, 32'd0);
    checkOutput("mfhi_after_mthi", 64'(mHi), 64'h1234);

    // Abort a long operation with reset after HI/LO hold non-zero values.
    runOp(F_MTLO, 32'h0000_00AA, 32'd0);
`ifdef MULDIV_DIVIDE_EN
    applyStimulus(1'b1, F_DIV, 32'd100, 32'd7);
`else
    applyStimulus(1'b1, F_MULT, 32'd100, 32'd7);
`endif
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    checkOutput("busy_before_abort", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_hi", 64'(bus.hi), 64'd0);
    checkOutput("abort_lo", 64'(bus.lo), 64'd0);
    mHi = '0;
    mLo = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runOp(F_MULT, 32'd2, 32'd5);
    checkOutput("mult_after_abort_lo", 64'(bus.lo), 64'd10);

    for (int i = 0; i < 24; i++) begin
      runOp(functTable[$urandom_range(0, 8)], randOperand(), randOperand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
